xyzw_manager_pipe: RTL and testbench
====================================

XYZW_MANAGER_PIPE -- requirements
Module: xyzw_manager_pipe

Interface
REQ-001 Parameter DATA_W, default 48, datapath width of W/X/Y/Z, P, C, AB, PCIN and the RND word.
REQ-002 Parameter M_W, default 45, partial-product width of M1/M2; legal range 2..DATA_W.
REQ-003 Parameter SIMD_W, default 16, SIMD carry-chain width.
REQ-004 Parameter SHIFT, default 17, arithmetic right-shift amount for the shifted Z modes; legal range 1..DATA_W-1.
REQ-005 Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- opmode, input, 9: mode word.
- opmode_ce, input, 1: opmode register load enable.
- P, C, AB, PCIN, input, DATA_W each: operand sources.
- M1, M2, input, M_W each: partial products.
- M_SIMD_carry, input, SIMD_W: SIMD carry in.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: stage can accept.
- out_valid, output, 1: outputs valid.
- out_ready, input, 1: consumer accepts.
- W, X, Y, Z, output, DATA_W each: registered mux outputs.
- M_SIMD_carry_Mux, output, SIMD_W: registered gated carry.
- sel_err, output, 1: registered flag, RND selected before the RND chain is loaded.
- configuration_input, input, 1: serial configuration in.
- configuration_enable, input, 1: shift enable.
- configuration_output, output, 1: serial out, equals RND[DATA_W-1].
- cfg_ready, output, 1: RND chain fully loaded.

Function
REQ-006 opmode_q SHALL load opmode on a clk edge with opmode_ce=1, and all muxing SHALL use opmode_q only.
REQ-007 With configuration_enable=1, RND SHALL shift left one bit per cycle, taking configuration_input into bit 0.
REQ-008 The configuration FSM SHALL have states IDLE, SHIFT and LOCKED: IDLE->SHIFT on the first enabled cycle; SHIFT->LOCKED on the enabled cycle where the bit count reaches DATA_W; no other exits except reset.
REQ-009 The bit counter SHALL saturate at DATA_W; in LOCKED, shifting SHALL continue for daisy-chaining, and cfg_ready=1 iff the state is LOCKED.
REQ-010 The W source SHALL be: opmode_q[8:7] = 00 selects 0, 01 selects P, 10 selects RND, 11 selects C.
REQ-011 If W selects RND with cfg_ready=0, W SHALL be 0 and sel_err SHALL be 1 for that transfer; otherwise sel_err SHALL be 0.
REQ-012 The X source SHALL be: opmode_q[1:0] = 00 selects 0, 01 selects ext(M1), 10 selects P, 11 selects AB.
REQ-013 The Y source SHALL be: opmode_q[3:2] = 00 selects 0, 01 selects ext(M2), 10 selects all-ones, 11 selects C.
REQ-014 The Z source SHALL be: opmode_q[6:4] = 000 selects 0, 001 selects PCIN, 010 selects P, 011 selects C, 100 selects P, 101 selects PCIN>>>SHIFT, 110 selects P>>>SHIFT, 111 selects 0 (defined, never X).
REQ-015 M_SIMD_carry_Mux SHALL be M_SIMD_carry when opmode_q[3:0]=0101, and 0 otherwise.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-017 On in_valid && in_ready, all outputs SHALL register the selected values and out_valid SHALL be 1 on the next cycle: latency 1, throughput 1 per cycle.
REQ-018 When out_valid=1 and out_ready=0, all outputs SHALL hold unchanged regardless of input changes.
REQ-019 When out_ready=1 and in_valid=0, out_valid SHALL drop to 0 the next cycle, and the data outputs SHALL hold their last values.
REQ-020 An opmode_ce pulse and a transfer in the same cycle SHALL use the old opmode_q for that transfer.

Reset
REQ-021 When rst_n=0 at a clk edge, the following SHALL clear to 0: opmode_q, RND, the bit counter, W/X/Y/Z, M_SIMD_carry_Mux, out_valid and sel_err; the FSM SHALL go to IDLE.
REQ-022 Reset SHALL override configuration_enable and transfers in the same cycle, and a partially loaded chain SHALL restart from count 0.

Configuration
REQ-023 With macro XYZW_SIGNEXT_EN defined, ext() SHALL sign-extend from bit M_W-1 to DATA_W.
REQ-024 With XYZW_SIGNEXT_EN undefined, ext() SHALL zero-extend.

Verification
REQ-025 Reset, then 47 enabled shift cycles -> cfg_ready=0; cycle 48 -> cfg_ready=1; RND equals the shifted pattern, and configuration_output equals bit 47.
REQ-026 Before load, opmode 9'b10_000_0000 with a transfer -> W=0 and sel_err=1; after loading 0x0000_0000_8000 -> W=0x0000_0000_8000 and sel_err=0.
REQ-027 opmode_q[6:4]=110, P=0x8000_0000_0000 -> Z=0xFFFF_C000_0000 (SHIFT=17) one cycle after the transfer.
REQ-028 opmode_q[3:0]=0101, M1=45'h1000_0000_0000, M_SIMD_carry=16'hA5A5 -> X=0x1000_0000_0000 with SIGNEXT_EN off, or 0xF000_0000_0000 with it on; carry out=16'hA5A5; opmode 0001 -> carry out=0.
REQ-029 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen; release -> one transfer per cycle with no loss or duplication.
REQ-030 rst_n=0 mid-shift at count 20 with out_valid=1 -> next cycle all outputs 0, out_valid=0, FSM IDLE, and 48 further shifts are required for cfg_ready.

Source files
------------

// File: rtl/xyzw_manager_pipe.sv
// W/X/Y/Z operand selector with a one-deep valid/ready output stage and a serially loaded RND word.
// Optional macro XYZW_SIGNEXT_EN: sign-extend M1/M2 into the datapath instead of zero-extending.
module xyzw_manager_pipe #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned M_W    = 45,
    parameter int unsigned SIMD_W = 16,
    parameter int unsigned SHIFT  = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        opmode,
    input  logic              opmode_ce,
    input  logic [DATA_W-1:0] P,
    input  logic [DATA_W-1:0] C,
    input  logic [DATA_W-1:0] AB,
    input  logic [DATA_W-1:0] PCIN,
    input  logic [M_W-1:0]    M1,
    input  logic [M_W-1:0]    M2,
    input  logic [SIMD_W-1:0] M_SIMD_carry,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] W,
    output logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] Z,
    output logic [SIMD_W-1:0] M_SIMD_carry_Mux,
    output logic              sel_err,
    input  logic              configuration_input,
    input  logic              configuration_enable,
    output logic              configuration_output,
    output logic              cfg_ready
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_SHIFT  = 2'd1,
        CFG_LOCKED = 2'd2
    } cfg_state_e;

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rnd_q, rnd_d;
    logic [8:0]        opmode_q, opmode_d;
    logic [DATA_W-1:0] w_q, w_d, x_q, x_d, y_q, y_d, z_q, z_d;
    logic [SIMD_W-1:0] carry_q, carry_d;
    logic              sel_err_q, sel_err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] ext_m1, ext_m2;
    logic              xfer;

`ifdef XYZW_SIGNEXT_EN
    assign ext_m1 = DATA_W'($signed(M1));
    assign ext_m2 = DATA_W'($signed(M2));
`else
    assign ext_m1 = DATA_W'(M1);
    assign ext_m2 = DATA_W'(M2);
`endif

    assign in_ready             = !valid_q || out_ready;
    assign xfer                 = in_valid && in_ready;
    assign cfg_ready            = (state_q == CFG_LOCKED);
    assign configuration_output = rnd_q[DATA_W-1];
    assign out_valid            = valid_q;
    assign W                    = w_q;
    assign X                    = x_q;
    assign Y                    = y_q;
    assign Z                    = z_q;
    assign M_SIMD_carry_Mux     = carry_q;
    assign sel_err              = sel_err_q;

    // RND chain keeps shifting after lock so several blocks can be daisy-chained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        if (configuration_enable) begin
            rnd_d = {rnd_q[DATA_W-2:0], configuration_input};
            if (cnt_q != CNT_W'(DATA_W)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                CFG_IDLE:   state_d = CFG_SHIFT;
                CFG_SHIFT:  if (cnt_d == CNT_W'(DATA_W)) state_d = CFG_LOCKED;
                CFG_LOCKED: state_d = CFG_LOCKED;
                default:    state_d = CFG_IDLE;
            endcase
        end
    end

    // Operand muxes; a transfer sees the opmode_q in effect before any same-cycle load.
    always_comb begin
        opmode_d  = opmode_ce ? opmode : opmode_q;
        w_d       = w_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        carry_d   = carry_q;
        sel_err_d = sel_err_q;
        valid_d   = valid_q;
        if (xfer) begin
            valid_d   = 1'b1;
            sel_err_d = 1'b0;
            unique case (opmode_q[8:7])
                2'b00: w_d = '0;
                2'b01: w_d = P;
                2'b10: begin
                    w_d       = cfg_ready ? rnd_q : '0;
                    sel_err_d = !cfg_ready;
                end
                default: w_d = C;
            endcase
            unique case (opmode_q[1:0])
                2'b00:   x_d = '0;
                2'b01:   x_d = ext_m1;
                2'b10:   x_d = P;
                default: x_d = AB;
            endcase
            unique case (opmode_q[3:2])
                2'b00:   y_d = '0;
                2'b01:   y_d = ext_m2;
                2'b10:   y_d = '1;
                default: y_d = C;
            endcase
            unique case (opmode_q[6:4])
                3'b001:  z_d = PCIN;
                3'b010:  z_d = P;
                3'b011:  z_d = C;
                3'b100:  z_d = P;
                3'b101:  z_d = DATA_W'($signed(PCIN) >>> SHIFT);
                3'b110:  z_d = DATA_W'($signed(P) >>> SHIFT);
                default: z_d = '0;
            endcase
            carry_d = (opmode_q[3:0] == 4'b0101) ? M_SIMD_carry : '0;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CFG_IDLE;
            cnt_q     <= '0;
            rnd_q     <= '0;
            opmode_q  <= '0;
            w_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            carry_q   <= '0;
            sel_err_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rnd_q     <= rnd_d;
            opmode_q  <= opmode_d;
            w_q       <= w_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            carry_q   <= carry_d;
            sel_err_q <= sel_err_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_xyzw_manager_pipe.sv
// Bench for xyzw_manager_pipe: directed scenarios plus random traffic against a transaction-level model.
module tb_xyzw_manager_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  opmode;
    logic        opmode_ce;
    logic [47:0] P, C, AB, PCIN;
    logic [44:0] M1, M2;
    logic [15:0] M_SIMD_carry;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [47:0] W, X, Y, Z;
    logic [15:0] M_SIMD_carry_Mux;
    logic        sel_err;
    logic        configuration_input, configuration_enable, configuration_output, cfg_ready;

    xyzw_manager_pipe dut (
        .clk(clk), .rst_n(rst_n), .opmode(opmode), .opmode_ce(opmode_ce),
        .P(P), .C(C), .AB(AB), .PCIN(PCIN), .M1(M1), .M2(M2),
        .M_SIMD_carry(M_SIMD_carry), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .W(W), .X(X), .Y(Y), .Z(Z), .M_SIMD_carry_Mux(M_SIMD_carry_Mux),
        .sel_err(sel_err), .configuration_input(configuration_input),
        .configuration_enable(configuration_enable),
        .configuration_output(configuration_output), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [8:0]  m_op;
    logic [47:0] m_rnd;
    int          m_cnt;
    logic        m_valid, m_err;
    logic [47:0] m_w, m_x, m_y, m_z;
    logic [15:0] m_carry;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] ext_m(input logic [44:0] m);
        logic [47:0] v;
        v = {3'b000, m};
`ifdef XYZW_SIGNEXT_EN
        if (m[44]) v = v | 48'hE000_0000_0000;
`endif
        return v;
    endfunction

    // Arithmetic shift by 17 done as signed integer division by 2^17 rounding toward -inf.
    function automatic logic [47:0] asr17(input logic [47:0] v);
        longint s;
        s = v[47] ? (longint'(v) - (longint'(1) <<< 48)) : longint'(v);
        s = s >>> 17;
        return 48'(s);
    endfunction

    task automatic model_update();
        logic ready;
        if (!rst_n) begin
            m_op = '0; m_rnd = '0; m_cnt = 0; m_valid = 0; m_err = 0;
            m_w = '0; m_x = '0; m_y = '0; m_z = '0; m_carry = '0;
            return;
        end
        ready = (m_cnt >= 48);
        if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_err   = (m_op[8:7] == 2'd2) && !ready;
            case (m_op[8:7])
                2'd0: m_w = 0;
                2'd1: m_w = P;
                2'd2: m_w = ready ? m_rnd : 48'd0;
                default: m_w = C;
            endcase
            case (m_op[1:0])
                2'd0: m_x = 0;
                2'd1: m_x = ext_m(M1);
                2'd2: m_x = P;
                default: m_x = AB;
            endcase
            case (m_op[3:2])
                2'd0: m_y = 0;
                2'd1: m_y = ext_m(M2);
                2'd2: m_y = 48'hFFFF_FFFF_FFFF;
                default: m_y = C;
            endcase
            case (m_op[6:4])
                3'd1: m_z = PCIN;
                3'd2, 3'd4: m_z = P;
                3'd3: m_z = C;
                3'd5: m_z = asr17(PCIN);
                3'd6: m_z = asr17(P);
                default: m_z = 0;
            endcase
            m_carry = (m_op[3:0] == 4'b0101) ? M_SIMD_carry : 16'd0;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (opmode_ce) m_op = opmode;
        if (configuration_enable) begin
            m_rnd = {m_rnd[46:0], configuration_input};
            if (m_cnt < 48) m_cnt++;
        end
    endtask

    task automatic check_outputs();
        chk_eq("out_valid", 64'(out_valid), 64'(m_valid));
        chk_eq("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk_eq("W", 64'(W), 64'(m_w));
        chk_eq("X", 64'(X), 64'(m_x));
        chk_eq("Y", 64'(Y), 64'(m_y));
        chk_eq("Z", 64'(Z), 64'(m_z));
        chk_eq("carry", 64'(M_SIMD_carry_Mux), 64'(m_carry));
        chk_eq("sel_err", 64'(sel_err), 64'(m_err));
        chk_eq("cfg_ready", 64'(cfg_ready), 64'(m_cnt >= 48));
        chk_eq("cfg_out", 64'(configuration_output), 64'(m_rnd[47]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_data();
        P    = {16'($urandom), $urandom};
        C    = {16'($urandom), $urandom};
        AB   = {16'($urandom), $urandom};
        PCIN = {16'($urandom), $urandom};
        M1   = {13'($urandom), $urandom};
        M2   = {13'($urandom), $urandom};
        M_SIMD_carry = 16'($urandom);
    endtask

    task automatic load_op(input logic [8:0] op);
        opmode = op; opmode_ce = 1; in_valid = 0;
        step();
        opmode_ce = 0;
    endtask

    logic [47:0] pat;
    logic [47:0] exp_x;

    initial begin
        rst_n = 0; opmode = '0; opmode_ce = 0; in_valid = 0; out_ready = 1;
        configuration_input = 0; configuration_enable = 0;
        rand_data();
        step(); step();
        chk_eq("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1;

        // RND selected before the chain is loaded
        load_op(9'b10_000_0000);
        in_valid = 1; step(); in_valid = 0;
        chk_eq("pre_load_w", 64'(W), 64'd0);
        chk_eq("pre_load_err", 64'(sel_err), 64'd1);

        // Load 48 bits MSB first
        pat = 48'h0000_0000_8000;
        configuration_enable = 1;
        for (int k = 0; k < 48; k++) begin
            configuration_input = pat[47 - k];
            step();
            if (k == 46) chk_eq("cfg_ready_47", 64'(cfg_ready), 64'd0);
        end
        configuration_enable = 0;
        chk_eq("cfg_ready_48", 64'(cfg_ready), 64'd1);
        chk_eq("cfg_out_bit47", 64'(configuration_output), 64'(pat[47]));
        in_valid = 1; step(); in_valid = 0;
        chk_eq("post_load_w", 64'(W), 64'h0000_0000_8000);
        chk_eq("post_load_err", 64'(sel_err), 64'd0);

        // Shifted Z of a negative P
        load_op(9'b00_110_0000);
        P = 48'h8000_0000_0000; in_valid = 1; step(); in_valid = 0;
        chk_eq("z_asr", 64'(Z), 64'hFFFF_C000_0000);

        // M1 extension and SIMD carry gating
        load_op(9'b00_000_0101);
        M1 = 45'h1000_0000_0000; M_SIMD_carry = 16'hA5A5; in_valid = 1; step(); in_valid = 0;
`ifdef XYZW_SIGNEXT_EN
        exp_x = 48'hF000_0000_0000;
`else
        exp_x = 48'h1000_0000_0000;
`endif
        chk_eq("x_ext", 64'(X), 64'(exp_x));
        chk_eq("carry_on", 64'(M_SIMD_carry_Mux), 64'hA5A5);
        load_op(9'b00_000_0001);
        in_valid = 1; step(); in_valid = 0;
        chk_eq("carry_off", 64'(M_SIMD_carry_Mux), 64'd0);

        // Backpressure: stall three cycles with changing inputs, then stream
        load_op(9'b01_011_1111);
        in_valid = 1; out_ready = 1; rand_data(); step();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            rand_data(); step();
            chk_eq("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin rand_data(); step(); end
        in_valid = 0; step();
        chk_eq("drain_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a shift with a valid output pending
        rst_n = 0; step(); rst_n = 1;
        configuration_enable = 1;
        for (int k = 0; k < 20; k++) begin configuration_input = 1'($urandom); step(); end
        in_valid = 1; rand_data(); step();
        chk_eq("mid_valid", 64'(out_valid), 64'd1);
        rst_n = 0; step(); rst_n = 1; in_valid = 0;
        chk_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        chk_eq("mid_rst_x", 64'(X), 64'd0);
        chk_eq("mid_rst_ready", 64'(cfg_ready), 64'd0);
        for (int k = 0; k < 48; k++) begin
            configuration_input = 1'($urandom);
            step();
            if (k == 46) chk_eq("reload_47", 64'(cfg_ready), 64'd0);
        end
        chk_eq("reload_48", 64'(cfg_ready), 64'd1);
        configuration_enable = 0;

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            opmode = 9'($urandom);
            opmode_ce = ($urandom_range(0, 3) == 0);
            configuration_enable = ($urandom_range(0, 1) == 0);
            configuration_input = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_data();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
